n_bit_register_write_arbiter: RTL and testbench

Round-robin arbiter that shares a bank of D n-bit registers between R requesters. Each cycle it selects one pending write request and drives a one-hot per-register enable plus a shared data bus. The enable and data outputs feed the enable and data inputs of the bank's register instances, which share the same in_clk and in_nres. Sits between requesting datapath blocks and the register bank.

---
 rtl/n_bit_register_write_arbiter.sv | 94 +++++++++
 tb/tb_n_bit_register_write_arbiter.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/n_bit_register_write_arbiter.sv
// Round-robin write arbiter sharing a bank of D n-bit registers between R requesters.
// Emits a registered one-hot ack, one-hot register enable and shared write data per grant.
module n_bit_register_write_arbiter #(
  parameter int unsigned n = 8,
  parameter int unsigned R = 4,
  parameter int unsigned D = 4,
  parameter int unsigned A = 2
) (
  input  logic                 in_clk,
  input  logic                 in_nres,
  input  logic [R-1:0]         in_req,
  input  logic [R*A-1:0]       in_addr,
  input  logic [R*n-1:0]       in_data,
  input  logic                 in_hold,
  output logic [R-1:0]         out_ack,
  output logic                 out_err,
  output logic [D-1:0]         out_wr_en,
  output logic [n-1:0]         out_wr_data,
  output logic [$clog2(R)-1:0] out_grant_id
);

  localparam int unsigned GW = $clog2(R);

  logic [GW-1:0] ptr_q;
  logic [GW-1:0] gnt;
  logic [GW-1:0] ptr_nxt;
  logic [R-1:0]  eligible;
  logic [R-1:0]  ack_nxt;
  logic          found;
  logic          grant_valid;
  logic          addr_ok;
  logic [A-1:0]  sel_addr;
  logic [n-1:0]  sel_data;
  logic [D-1:0]  wr_en_nxt;
  int unsigned   idx;

  // The requester acked this cycle may still show req high, so it is masked out.
  always_comb begin
    eligible = in_req & ~out_ack;
    found    = 1'b0;
    gnt      = '0;
    idx      = 0;
    for (int unsigned k = 0; k < R; k++) begin
      idx = 32'(ptr_q) + k;
      if (idx >= R) idx = idx - R;
      if (!found && eligible[GW'(idx)]) begin
        found = 1'b1;
        gnt   = GW'(idx);
      end
    end
  end

  always_comb begin
    grant_valid = found & ~in_hold;
    sel_addr    = in_addr[gnt*A +: A];
    sel_data    = in_data[gnt*n +: n];
    addr_ok     = (32'(sel_addr) < D);
    wr_en_nxt   = '0;
    for (int unsigned j = 0; j < D; j++) begin
      wr_en_nxt[j] = addr_ok && (32'(sel_addr) == j);
    end
    ack_nxt      = '0;
    ack_nxt[gnt] = 1'b1;
    ptr_nxt      = (32'(gnt) == R - 1) ? '0 : gnt + 1'b1;
  end

  always_ff @(posedge in_clk or negedge in_nres) begin
    if (!in_nres) begin
      ptr_q        <= '0;
      out_ack      <= '0;
      out_err      <= 1'b0;
      out_wr_en    <= '0;
      out_wr_data  <= '0;
      out_grant_id <= '0;
    end else if (grant_valid) begin
      ptr_q        <= ptr_nxt;
      out_ack      <= ack_nxt;
      out_err      <= ~addr_ok;
      out_wr_en    <= wr_en_nxt;
      out_wr_data  <= addr_ok ? sel_data : '0;
      out_grant_id <= gnt;
    end else begin
      out_ack      <= '0;
      out_err      <= 1'b0;
      out_wr_en    <= '0;
      out_wr_data  <= '0;
    end
  end

  a_ack_onehot: assert property (@(posedge in_clk) disable iff (!in_nres) $onehot0(out_ack));
  a_wr_onehot:  assert property (@(posedge in_clk) disable iff (!in_nres) $onehot0(out_wr_en));
  a_err_ack:    assert property (@(posedge in_clk) disable iff (!in_nres) out_err |-> (out_ack != '0));

endmodule

// File: tb/tb_n_bit_register_write_arbiter.sv
// Self-checking bench: directed scenarios plus random traffic against a behavioural arbiter/bank model.
module tb_n_bit_register_write_arbiter;

  localparam int unsigned N  = 8;
  localparam int unsigned R  = 4;
  localparam int unsigned D  = 3;
  localparam int unsigned A  = 2;
  localparam int unsigned GW = 2;

  logic           clk  = 1'b0;
  logic           nres = 1'b0;
  logic           hold = 1'b0;
  logic [R-1:0]   req  = '0;
  logic [A-1:0]   addr_a [R];
  logic [N-1:0]   data_a [R];
  logic [R*A-1:0] addr_p;
  logic [R*N-1:0] data_p;

  logic [R-1:0]   ack;
  logic           err;
  logic [D-1:0]   wr_en;
  logic [N-1:0]   wr_data;
  logic [GW-1:0]  gid;
  logic [N-1:0]   bank [D];

  int n_checks = 0;
  int n_pass   = 0;

  // behavioural model state
  int           m_ptr;
  logic [R-1:0] m_ack;
  logic         m_err;
  logic [D-1:0] m_wr_en;
  logic [N-1:0] m_wr_data;
  int           m_gid;
  logic [N-1:0] m_bank [D];
  int           cnt [R];

  always #5 clk = ~clk;

  always_comb begin
    addr_p = '0;
    data_p = '0;
    for (int i = 0; i < R; i++) begin
      addr_p[i*A +: A] = addr_a[i];
      data_p[i*N +: N] = data_a[i];
    end
  end

  n_bit_register_write_arbiter #(.n(N), .R(R), .D(D), .A(A)) dut (
    .in_clk       (clk),
    .in_nres      (nres),
    .in_req       (req),
    .in_addr      (addr_p),
    .in_data      (data_p),
    .in_hold      (hold),
    .out_ack      (ack),
    .out_err      (err),
    .out_wr_en    (wr_en),
    .out_wr_data  (wr_data),
    .out_grant_id (gid)
  );

  // Register bank fed by the arbiter outputs
  always_ff @(posedge clk or negedge nres) begin
    if (!nres) begin
      for (int j = 0; j < D; j++) bank[j] <= '0;
    end else begin
      for (int j = 0; j < D; j++) if (wr_en[j]) bank[j] <= wr_data;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic model_reset();
    m_ptr = 0; m_ack = '0; m_err = 1'b0; m_wr_en = '0; m_wr_data = '0; m_gid = 0;
    for (int j = 0; j < D; j++) m_bank[j] = '0;
  endtask

  task automatic step();
    int g;
    int a;
    @(posedge clk);
    for (int j = 0; j < D; j++) if (m_wr_en[j]) m_bank[j] = m_wr_data;
    g = -1;
    if (!hold) begin
      for (int k = 0; k < R; k++) begin
        int i;
        i = (m_ptr + k) % R;
        if (g < 0 && req[i] && !m_ack[i]) g = i;
      end
    end
    m_ack = '0; m_err = 1'b0; m_wr_en = '0; m_wr_data = '0;
    if (g >= 0) begin
      m_ack[g] = 1'b1;
      a = int'(addr_a[g]);
      if (a < D) begin
        m_wr_en[a] = 1'b1;
        m_wr_data  = data_a[g];
      end else begin
        m_err = 1'b1;
      end
      m_gid = g;
      m_ptr = (g + 1) % R;
    end
    @(negedge clk);
    check("ack",     32'(ack),     32'(m_ack));
    check("err",     32'(err),     32'(m_err));
    check("wr_en",   32'(wr_en),   32'(m_wr_en));
    check("wr_data", 32'(wr_data), 32'(m_wr_data));
    check("gid",     32'(gid),     32'(m_gid));
    for (int j = 0; j < D; j++) check("bank", 32'(bank[j]), 32'(m_bank[j]));
    for (int i = 0; i < R; i++) if (ack[i] === 1'b1) cnt[i]++;
  endtask

  task automatic drop_acked();
    for (int i = 0; i < R; i++) if (m_ack[i]) req[i] = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2 nres = 1'b0;
    #1;
    check("rst_ack",     32'(ack),     32'd0);
    check("rst_err",     32'(err),     32'd0);
    check("rst_wr_en",   32'(wr_en),   32'd0);
    check("rst_wr_data", 32'(wr_data), 32'd0);
    check("rst_gid",     32'(gid),     32'd0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    nres = 1'b1;
  endtask

  initial begin
    logic prev;
    for (int i = 0; i < R; i++) begin addr_a[i] = '0; data_a[i] = '0; cnt[i] = 0; end
    model_reset();
    repeat (2) @(negedge clk);
    nres = 1'b1;

    // hold freezes grants and pointer
    req = 4'b0011; hold = 1'b1;
    for (int k = 0; k < 3; k++) begin step(); check("hold_ack", 32'(ack), 32'd0); end
    hold = 1'b0;
    step(); check("hold_g0", 32'(ack), 32'b0001); drop_acked();
    step(); check("hold_g1", 32'(ack), 32'b0010); drop_acked();
    step();

    // single write
    req = 4'b0100; addr_a[2] = 2'd2; data_a[2] = 8'hA5;
    step();
    check("sw_ack", 32'(ack), 32'b0100);
    check("sw_en",  32'(wr_en), 32'b100);
    check("sw_dat", 32'(wr_data), 32'hA5);
    check("sw_gid", 32'(gid), 32'd2);
    drop_acked();
    step(); check("sw_bank", 32'(bank[2]), 32'hA5);

    // reset mid-grant, then fairness with all requesting
    addr_a[0] = 2'd0; addr_a[1] = 2'd1; addr_a[2] = 2'd2; addr_a[3] = 2'd0;
    for (int i = 0; i < R; i++) data_a[i] = 8'(8'h10 + i);
    req = 4'b1111;
    step(); step();
    do_reset();
    for (int i = 0; i < R; i++) cnt[i] = 0;
    for (int k = 0; k < 8; k++) begin
      step();
      check("fair_gid", 32'(gid), 32'(k % 4));
    end
    for (int i = 0; i < R; i++) check("fair_cnt", 32'(cnt[i]), 32'd2);
    req = '0; step();

    // ack mask: lone requester served every other cycle
    for (int i = 0; i < R; i++) cnt[i] = 0;
    req = 4'b0010; prev = 1'b0;
    for (int k = 0; k < 6; k++) begin
      step();
      check("mask_consec", 32'(ack[1] & prev), 32'd0);
      prev = ack[1];
    end
    check("mask_cnt", 32'(cnt[1]), 32'd3);
    req = '0; step();

    // bad address, pointer moved to 0 first via requester 3
    req = 4'b1000; step(); drop_acked();
    req = 4'b0011; addr_a[0] = 2'd3; data_a[0] = 8'hFF; addr_a[1] = 2'd1; data_a[1] = 8'h3C;
    step();
    check("bad_ack", 32'(ack), 32'b0001);
    check("bad_err", 32'(err), 32'd1);
    check("bad_en",  32'(wr_en), 32'd0);
    drop_acked();
    step();
    check("bad_next", 32'(gid), 32'd1);
    drop_acked();
    step();

    // random traffic
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < R; i++) begin
        if (m_ack[i]) begin
          if ($urandom_range(1, 0) == 0) req[i] = 1'b0;
          else begin addr_a[i] = 2'($urandom_range(3, 0)); data_a[i] = 8'($urandom); end
        end else if (!req[i] && $urandom_range(9, 0) < 4) begin
          req[i] = 1'b1;
          addr_a[i] = 2'($urandom_range(3, 0));
          data_a[i] = 8'($urandom);
        end
      end
      hold = ($urandom_range(9, 0) == 0);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
